// File: rtl/bmp_pkg.sv
// bmp_pkg: shared definitions for the BMP frame-store read path.
//   - FSM state encoding for the frame reader
//   - pixel geometry constants (BYTES_PER_PIXEL, ROW_ALIGN)
//   - pixel FIFO entry widths
//   - calc_stride(): byte distance between successive line starts
// Build option: FRAME_READER_PAD_EN selects 4-byte aligned line stride;
// when undefined, lines are packed back to back (stride = width*3).
package bmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BYTES_PER_PIXEL = 3;
    localparam int ROW_ALIGN       = 4;
    localparam int PIX_W           = 24;
    localparam int FIFO_W          = PIX_W + 2;

    // Line stride in bytes for a line of 'w' pixels.
    function automatic logic [31:0] calc_stride(input logic [31:0] w);
        logic [31:0] raw_s;
        raw_s = w * 32'(BYTES_PER_PIXEL);
`ifdef FRAME_READER_PAD_EN
        calc_stride = (raw_s + 32'(ROW_ALIGN - 1)) & ~32'(ROW_ALIGN - 1);
`else
        calc_stride = raw_s;
`endif
    endfunction

endpackage

// File: rtl/mod_frame_reader_if.sv
// mod_frame_reader_if: byte-store read bus plus pixel stream of the frame reader.
//   mem_rd / mem_addr   : byte read request (reader -> store)
//   mem_rdata           : read data, one cycle after mem_rd (store -> reader)
//   pix_valid/pix_ready : pixel stream handshake
//   pix_data            : {R,G,B}
//   pix_sof / pix_eol   : first pixel of frame / last pixel of line
// Modports: master = frame reader, slave = store + downstream consumer.
interface mod_frame_reader_if
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sof;
    logic              pix_eol;

    modport master (
        output mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eol,
        input  mem_rdata, pix_ready
    );

    modport slave (
        input  mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eol,
        output mem_rdata, pix_ready
    );
endinterface

// File: rtl/mod_pix_fifo.sv
// mod_pix_fifo: 2-entry synchronous FIFO for {pixel, sof, eol} entries.
//   clk, rst   : clock, synchronous active-high reset (flushes and zeroes storage)
//   push, din  : write request and entry
//   pop        : read request (head is consumed this cycle)
//   head       : current head entry (registered storage, stable until popped)
//   count      : occupancy 0..2
// Push and pop may coincide at any occupancy, including full.
module mod_pix_fifo
    import bmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FIFO_W-1:0] din,
    input  logic              pop,
    output logic [FIFO_W-1:0] head,
    output logic [1:0]        count
);
    logic [FIFO_W-1:0] mem_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok_s = push && ((count_r != 2'd2) || pop);
    assign pop_ok_s  = pop && (count_r != 2'd0);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/mod_frame_reader.sv
// mod_frame_reader: scans a 24-bit BMP pixel array out of the byte-wide frame
// store in raster order and emits it as a valid/ready {R,G,B} pixel stream.
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle request, honoured only when idle
//   base, width, height : first pixel byte address and frame size, sampled with start
//   busy                : frame in progress
//   done                : one-cycle pulse after the final pixel handshake
//                         (or the cycle after a start with a zero dimension)
//   bus (master)        : byte read bus and pixel stream, see mod_frame_reader_if
// Build option: FRAME_READER_PAD_EN pads each line to a 4-byte boundary.
// Each pixel is three back-to-back byte reads (B, G, R). B and G are held,
// R goes straight from mem_rdata into the pixel FIFO. A new pixel fetch is
// started only while FIFO occupancy plus pixels in flight is below two, so
// the FIFO can never overflow and reads simply pause under back-pressure.
module mod_frame_reader
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 12
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base,
    input  logic [DIM_W-1:0]   width,
    input  logic [DIM_W-1:0]   height,
    output logic               busy,
    output logic               done,
    mod_frame_reader_if.master bus
);
    state_t             state_r;
    state_t             state_n;
    logic [DIM_W-1:0]   width_r;
    logic [DIM_W-1:0]   height_r;
    logic [ADDR_W-1:0]  stride_r;
    logic [ADDR_W-1:0]  line_base_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DIM_W-1:0]   x_r;
    logic [DIM_W-1:0]   y_r;
    logic [1:0]         phase_r;
    logic [1:0]         inflight_r;
    logic               rd_v_r;
    logic [1:0]         rd_ph_r;
    logic               rd_sof_r;
    logic               rd_eol_r;
    logic [7:0]         b_r;
    logic [7:0]         g_r;
    logic               busy_r;
    logic               done_r;

    logic               zero_dim_s;
    logic               start_ok_s;
    logic               start_zero_s;
    logic               credit_ok_s;
    logic               issue_s;
    logic               last_x_s;
    logic               last_y_s;
    logic               last_read_s;
    logic               push_s;
    logic               pop_s;
    logic               final_pop_s;
    logic [FIFO_W-1:0]  fifo_din_s;
    logic [FIFO_W-1:0]  fifo_head_s;
    logic [1:0]         fifo_count_s;

    assign zero_dim_s   = (width == DIM_W'(0)) || (height == DIM_W'(0));
    assign start_ok_s   = (state_r == ST_IDLE) && start && !zero_dim_s;
    assign start_zero_s = (state_r == ST_IDLE) && start && zero_dim_s;
    assign credit_ok_s  = ({1'b0, fifo_count_s} + {1'b0, inflight_r}) < 3'd2;
    // Mid-pixel reads always continue; only the first byte of a pixel waits for credit.
    assign issue_s      = (state_r == ST_FETCH) && ((phase_r != 2'd0) || credit_ok_s);
    assign last_x_s     = (x_r == width_r - DIM_W'(1));
    assign last_y_s     = (y_r == height_r - DIM_W'(1));
    assign last_read_s  = issue_s && (phase_r == 2'd2) && last_x_s && last_y_s;
    assign push_s       = rd_v_r && (rd_ph_r == 2'd2);
    assign pop_s        = bus.pix_valid && bus.pix_ready;
    // The last pixel leaves when nothing else is buffered or still being read.
    assign final_pop_s  = (state_r == ST_DRAIN) && pop_s &&
                          (fifo_count_s == 2'd1) && (inflight_r == 2'd0);
    assign fifo_din_s   = {bus.mem_rdata, g_r, b_r, rd_sof_r, rd_eol_r};

    assign busy          = busy_r;
    assign done          = done_r;
    assign bus.mem_rd    = issue_s;
    assign bus.mem_addr  = addr_r;
    assign bus.pix_valid = (fifo_count_s != 2'd0);
    assign bus.pix_data  = fifo_head_s[FIFO_W-1:2];
    assign bus.pix_sof   = fifo_head_s[1];
    assign bus.pix_eol   = fifo_head_s[0];

    mod_pix_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .head  (fifo_head_s),
        .count (fifo_count_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_read_s) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (final_pop_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Frame parameters, raster walk and read address generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_r     <= '0;
            height_r    <= '0;
            stride_r    <= '0;
            line_base_r <= '0;
            addr_r      <= '0;
            x_r         <= '0;
            y_r         <= '0;
            phase_r     <= 2'd0;
        end else if (start_ok_s) begin
            width_r     <= width;
            height_r    <= height;
            stride_r    <= ADDR_W'(calc_stride(32'(width)));
            line_base_r <= base;
            addr_r      <= base;
            x_r         <= '0;
            y_r         <= '0;
            phase_r     <= 2'd0;
        end else if (issue_s) begin
            if (phase_r != 2'd2) begin
                phase_r <= phase_r + 2'd1;
                addr_r  <= addr_r + ADDR_W'(1);
            end else if (last_x_s) begin
                // Next line starts one stride after this line's start.
                phase_r     <= 2'd0;
                x_r         <= '0;
                y_r         <= y_r + DIM_W'(1);
                line_base_r <= line_base_r + stride_r;
                addr_r      <= line_base_r + stride_r;
            end else begin
                phase_r <= 2'd0;
                x_r     <= x_r + DIM_W'(1);
                addr_r  <= addr_r + ADDR_W'(1);
            end
        end
    end

    // Read-return tracking, byte capture, in-flight pixel count and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v_r     <= 1'b0;
            rd_ph_r    <= 2'd0;
            rd_sof_r   <= 1'b0;
            rd_eol_r   <= 1'b0;
            b_r        <= 8'd0;
            g_r        <= 8'd0;
            inflight_r <= 2'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rd_v_r   <= issue_s;
            rd_ph_r  <= phase_r;
            rd_sof_r <= (x_r == DIM_W'(0)) && (y_r == DIM_W'(0));
            rd_eol_r <= last_x_s;
            if (rd_v_r && (rd_ph_r == 2'd0)) begin
                b_r <= bus.mem_rdata;
            end
            if (rd_v_r && (rd_ph_r == 2'd1)) begin
                g_r <= bus.mem_rdata;
            end
            case ({issue_s && (phase_r == 2'd0), push_s})
                2'b10:   inflight_r <= inflight_r + 2'd1;
                2'b01:   inflight_r <= inflight_r - 2'd1;
                default: inflight_r <= inflight_r;
            endcase
            busy_r <= (state_n != ST_IDLE);
            done_r <= start_zero_s || final_pop_s;
        end
    end
endmodule
